// File: rtl/pong_engine.sv
// Pong game logic: ball, paddles, scores and game FSM, updated once per frame at the end of the visible area.
// Optional feature: define PONG_AI_EN to have the right paddle track the ball instead of p2_up/p2_down.
module pong_engine #(
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] xpix,
  input  logic [9:0] ypix,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic       start,
  output logic       pixval,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over
);
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;
  typedef logic signed [10:0] coord_t;

  localparam coord_t ZERO    = '0;
  localparam coord_t BS      = coord_t'(BALL_SIZE);
  localparam coord_t BS_HALF = coord_t'(BALL_SIZE / 2);
  localparam coord_t PH      = coord_t'(PADDLE_H);
  localparam coord_t PH_HALF = coord_t'(PADDLE_H / 2);
  localparam coord_t BSPD    = coord_t'(BALL_SPEED);
  localparam coord_t PSPD    = coord_t'(PADDLE_SPEED);
  localparam coord_t PY_MAX  = coord_t'(480 - PADDLE_H);
  localparam coord_t L_EDGE  = coord_t'(16);
  localparam coord_t L_FACE  = coord_t'(24);
  localparam coord_t R_FACE  = coord_t'(616);
  localparam coord_t R_EDGE  = coord_t'(624);
  localparam coord_t SCR_W   = coord_t'(640);
  localparam coord_t SCR_H   = coord_t'(480);

  localparam logic [9:0] BX0    = 10'd316;
  localparam logic [9:0] BY0    = 10'd236;
  localparam logic [9:0] PY0    = 10'd208;
  localparam logic [9:0] BX_LH  = 10'd24;
  localparam logic [9:0] BX_RH  = 10'(616 - BALL_SIZE);
  localparam logic [9:0] BY_MAX = 10'(480 - BALL_SIZE);
  localparam logic [3:0] WIN    = 4'(WIN_SCORE);

  localparam int CNT_W = (SERVE_FRAMES > 2) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

  state_t           state;
  logic [9:0]       bx, by, p1, p2;
  logic             dx, dy;
  logic [CNT_W-1:0] serve_cnt;

  // Buttons are asynchronous; two flops per bit before any use.
  logic [4:0] sync_a, sync_b;
  logic       up1, dn1, up2_btn, dn2_btn, start_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      // NOTE: non-blocking so sync_b takes the old sync_a, forming a real two-stage chain.
      sync_a <= {start, p2_down, p2_up, p1_down, p1_up};
      sync_b <= sync_a;
    end
  end

  assign {start_s, dn2_btn, up2_btn, dn1, up1} = sync_b;

  logic  tick;
  assign tick = (xpix == 10'd799) && (ypix == 10'd479);

  coord_t bx_s, by_s, p1_s, p2_s;
  assign bx_s = {1'b0, bx};
  assign by_s = {1'b0, by};
  assign p1_s = {1'b0, p1};
  assign p2_s = {1'b0, p2};

  function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up, input logic down);
    coord_t t;
    t = {1'b0, y};
    if (up && !down)      t = t - PSPD;
    else if (down && !up) t = t + PSPD;
    if (t < ZERO)        t = ZERO;
    else if (t > PY_MAX) t = PY_MAX;
    return t[9:0];
  endfunction

  logic up2, dn2;
`ifdef PONG_AI_EN
  assign up2 = (by_s + BS_HALF) < (p2_s + PH_HALF);
  assign dn2 = (by_s + BS_HALF) > (p2_s + PH_HALF);
`else
  assign up2 = up2_btn;
  assign dn2 = dn2_btn;
`endif

  // Candidate next ball state; misses are resolved in the FSM and override everything here.
  coord_t     nx, ny;
  logic       miss_l, miss_r, hit_l, hit_r;
  logic [9:0] bx_play, by_play;
  logic       dx_play, dy_play;

  always_comb begin
    // NOTE: every output is assigned before any branch, so no path can leave one holding a value (latch).
    nx      = dx ? bx_s + BSPD : bx_s - BSPD;
    ny      = dy ? by_s + BSPD : by_s - BSPD;
    miss_l  = nx <= ZERO;
    miss_r  = (nx + BS) >= SCR_W;
    hit_l   = !dx && (nx <= L_FACE) && (nx > L_EDGE) && (ny < p1_s + PH) && (ny + BS > p1_s);
    hit_r   = dx && (nx + BS >= R_FACE) && (nx + BS < R_EDGE) && (ny < p2_s + PH) && (ny + BS > p2_s);
    bx_play = nx[9:0];
    dx_play = dx;
    by_play = ny[9:0];
    dy_play = dy;
    if (hit_l) begin
      bx_play = BX_LH;
      dx_play = 1'b1;
    end else if (hit_r) begin
      bx_play = BX_RH;
      dx_play = 1'b0;
    end
    if (ny <= ZERO) begin
      by_play = '0;
      dy_play = 1'b1;
    end else if (ny + BS >= SCR_H) begin
      by_play = BY_MAX;
      dy_play = 1'b0;
    end
  end

  logic [3:0] score_l_inc, score_r_inc;
  assign score_l_inc = (score_l == WIN) ? score_l : score_l + 4'd1;
  assign score_r_inc = (score_r == WIN) ? score_r : score_r + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bx        <= BX0;
      by        <= BY0;
      p1        <= PY0;
      p2        <= PY0;
      dx        <= 1'b1;
      dy        <= 1'b1;
      serve_cnt <= '0;
      score_l   <= '0;
      score_r   <= '0;
      game_over <= 1'b0;
    end else if (tick) begin
      if (state == SERVE || state == PLAY) begin
        p1 <= paddle_step(p1, up1, dn1);
        p2 <= paddle_step(p2, up2, dn2);
      end
      case (state)
        IDLE: if (start_s) state <= SERVE;
        SERVE: begin
          if (serve_cnt == CNT_LAST) begin
            serve_cnt <= '0;
            state     <= PLAY;
          end else begin
            serve_cnt <= serve_cnt + 1'b1;
          end
        end
        PLAY: begin
          if (miss_l) begin
            score_r   <= score_r_inc;
            dx        <= 1'b1;
            bx        <= BX0;
            by        <= BY0;
            state     <= (score_r_inc == WIN) ? OVER : SERVE;
            game_over <= (score_r_inc == WIN);
          end else if (miss_r) begin
            score_l   <= score_l_inc;
            dx        <= 1'b0;
            bx        <= BX0;
            by        <= BY0;
            state     <= (score_l_inc == WIN) ? OVER : SERVE;
            game_over <= (score_l_inc == WIN);
          end else begin
            bx <= bx_play;
            by <= by_play;
            dx <= dx_play;
            dy <= dy_play;
          end
        end
        OVER: begin
          if (start_s) begin
            score_l   <= '0;
            score_r   <= '0;
            game_over <= 1'b0;
            state     <= SERVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [10:0] xe, ye;
  logic        in_ball, in_lpad, in_rpad;
  assign xe      = {1'b0, xpix};
  assign ye      = {1'b0, ypix};
  assign in_ball = (xe >= {1'b0, bx}) && (xe < {1'b0, bx} + 11'(BALL_SIZE)) &&
                   (ye >= {1'b0, by}) && (ye < {1'b0, by} + 11'(BALL_SIZE));
  assign in_lpad = (xpix >= 10'd16) && (xpix <= 10'd23) &&
                   (ye >= {1'b0, p1}) && (ye < {1'b0, p1} + 11'(PADDLE_H));
  assign in_rpad = (xpix >= 10'd616) && (xpix <= 10'd623) &&
                   (ye >= {1'b0, p2}) && (ye < {1'b0, p2} + 11'(PADDLE_H));
  assign pixval  = (xpix < 10'd640) && (ypix < 10'd480) && (in_ball || in_lpad || in_rpad);

endmodule

// File: tb/tb_pong_engine.sv
// Testbench for pong_engine: drives frame ticks directly on xpix/ypix and scoreboards a game model against pixval and scores.
module tb_pong_engine;
  localparam int BS    = 8;
  localparam int PH    = 64;
  localparam int PSPD  = 4;
  localparam int BSPD  = 2;
  localparam int WIN   = 9;
  localparam int SF    = 60;
  localparam int IDLE  = 0;
  localparam int SERVE = 1;
  localparam int PLAY  = 2;
  localparam int OVER  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] xpix = '0;
  logic [9:0] ypix = '0;
  logic       p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0, start = 1'b0;
  logic       pixval;
  logic [3:0] score_l, score_r;
  logic       game_over;

  pong_engine #(
    .BALL_SIZE(BS), .PADDLE_H(PH), .PADDLE_SPEED(PSPD),
    .BALL_SPEED(BSPD), .WIN_SCORE(WIN), .SERVE_FRAMES(SF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .xpix(xpix), .ypix(ypix),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .start(start), .pixval(pixval), .score_l(score_l), .score_r(score_r),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bx, by, p1, p2, sl, sr, go;
  } snap_t;

  snap_t sb[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_ticks  = 0;

  int m_bx, m_by, m_p1, m_p2, m_dx, m_dy, m_sl, m_sr, m_state, m_cnt;

  task automatic model_reset();
    m_bx = 316; m_by = 236; m_p1 = 208; m_p2 = 208;
    m_dx = 1; m_dy = 1; m_sl = 0; m_sr = 0; m_state = IDLE; m_cnt = 0;
    sb.delete();
  endtask

  function automatic int pad_move(int y, bit up, bit dn);
    int r;
    r = y;
    if (up && !dn) r = r - PSPD;
    else if (dn && !up) r = r + PSPD;
    if (r < 0) r = 0;
    if (r > 480 - PH) r = 480 - PH;
    return r;
  endfunction

  task automatic model_step(input bit u1, input bit d1, input bit u2, input bit d2, input bit st);
    int nx, ny, np1, np2;
    np1 = m_p1;
    np2 = m_p2;
    if (m_state == SERVE || m_state == PLAY) begin
      np1 = pad_move(m_p1, u1, d1);
`ifdef PONG_AI_EN
      np2 = pad_move(m_p2, (m_by + BS / 2) < (m_p2 + PH / 2), (m_by + BS / 2) > (m_p2 + PH / 2));
`else
      np2 = pad_move(m_p2, u2, d2);
`endif
    end
    case (m_state)
      IDLE: if (st) m_state = SERVE;
      SERVE: begin
        if (m_cnt == SF - 1) begin m_cnt = 0; m_state = PLAY; end
        else m_cnt++;
      end
      PLAY: begin
        nx = m_bx + (m_dx ? BSPD : -BSPD);
        ny = m_by + (m_dy ? BSPD : -BSPD);
        if (nx <= 0) begin
          m_sr = (m_sr >= WIN) ? WIN : m_sr + 1;
          m_dx = 1; m_bx = 316; m_by = 236;
          m_state = (m_sr == WIN) ? OVER : SERVE;
        end else if (nx + BS >= 640) begin
          m_sl = (m_sl >= WIN) ? WIN : m_sl + 1;
          m_dx = 0; m_bx = 316; m_by = 236;
          m_state = (m_sl == WIN) ? OVER : SERVE;
        end else begin
          if (m_dx == 0 && nx <= 24 && nx > 16 && ny < m_p1 + PH && ny + BS > m_p1) begin
            nx = 24; m_dx = 1;
          end else if (m_dx == 1 && nx + BS >= 616 && nx + BS < 624 && ny < m_p2 + PH && ny + BS > m_p2) begin
            nx = 616 - BS; m_dx = 0;
          end
          if (ny <= 0) begin ny = 0; m_dy = 1; end
          else if (ny + BS >= 480) begin ny = 480 - BS; m_dy = 0; end
          m_bx = nx; m_by = ny;
        end
      end
      OVER: if (st) begin m_sl = 0; m_sr = 0; m_state = SERVE; end
      default: m_state = IDLE;
    endcase
    m_p1 = np1;
    m_p2 = np2;
  endtask

  function automatic snap_t snapshot();
    snap_t s;
    s.bx = m_bx; s.by = m_by; s.p1 = m_p1; s.p2 = m_p2;
    s.sl = m_sl; s.sr = m_sr; s.go = (m_state == OVER) ? 1 : 0;
    return s;
  endfunction

  function automatic bit pix_model(snap_t s, int x, int y);
    if (x >= 640 || y >= 480) return 1'b0;
    if (x >= s.bx && x < s.bx + BS && y >= s.by && y < s.by + BS) return 1'b1;
    if (x >= 16 && x <= 23 && y >= s.p1 && y < s.p1 + PH) return 1'b1;
    if (x >= 616 && x <= 623 && y >= s.p2 && y < s.p2 + PH) return 1'b1;
    return 1'b0;
  endfunction

  // Pops the expected frame state and compares scores plus probe pixels around every object edge.
  task automatic sb_compare();
    snap_t e;
    int    px[14];
    int    py[14];
    bit    want;
    if (sb.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL scoreboard_empty tick=%0d: got no entry, want one", n_ticks);
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (score_l !== 4'(e.sl)) begin
      n_errors++; $display("FAIL score_l tick=%0d: got %0d want %0d", n_ticks, score_l, e.sl);
    end
    n_checks++;
    if (score_r !== 4'(e.sr)) begin
      n_errors++; $display("FAIL score_r tick=%0d: got %0d want %0d", n_ticks, score_r, e.sr);
    end
    n_checks++;
    if (game_over !== e.go[0]) begin
      n_errors++; $display("FAIL game_over tick=%0d: got %b want %b", n_ticks, game_over, e.go[0]);
    end
    px = '{e.bx, e.bx + BS - 1, e.bx - 1, e.bx + BS, e.bx + 3, e.bx + 3,
           16, 23, 20, 20, 616, 623, 620, 620};
    py = '{e.by, e.by + BS - 1, e.by + 3, e.by + 3, e.by - 1, e.by + BS,
           e.p1, e.p1 + PH - 1, e.p1 - 1, e.p1 + PH, e.p2, e.p2 + PH - 1, e.p2 - 1, e.p2 + PH};
    for (int i = 0; i < 14; i++) begin
      if (px[i] >= 0 && py[i] >= 0) begin
        xpix = 10'(px[i]);
        ypix = 10'(py[i]);
        #1;
        want = pix_model(e, px[i], py[i]);
        n_checks++;
        if (pixval !== want) begin
          n_errors++;
          $display("FAIL pixval tick=%0d at (%0d,%0d): got %b want %b", n_ticks, px[i], py[i], pixval, want);
        end
      end
    end
    xpix = '0;
    ypix = '0;
  endtask

  task automatic do_tick(input bit u1, input bit d1, input bit u2, input bit d2, input bit st);
    @(negedge clk);
    p1_up = u1; p1_down = d1; p2_up = u2; p2_down = d2; start = st;
    repeat (3) @(negedge clk);
    xpix = 10'd799;
    ypix = 10'd479;
    model_step(u1, d1, u2, d2, st);
    sb.push_back(snapshot());
    @(negedge clk);
    xpix = '0;
    ypix = '0;
    n_ticks++;
    sb_compare();
  endtask

  // mode 0: idle, 1: follow the ball, 2: move away from the ball
  function automatic void steer(input int mode, input int pad_y, output bit up, output bit dn);
    int bc, pc;
    bc = m_by + BS / 2;
    pc = pad_y + PH / 2;
    up = 1'b0;
    dn = 1'b0;
    if (mode == 1) begin
      up = bc < pc - 2;
      dn = bc > pc + 2;
    end else if (mode == 2) begin
      up = bc >= pc;
      dn = bc < pc;
    end
  endfunction

  task automatic play_tick(input int mode1, input int mode2);
    bit u1, d1, u2, d2;
    steer(mode1, m_p1, u1, d1);
    steer(mode2, m_p2, u2, d2);
    do_tick(u1, d1, u2, d2, 1'b0);
  endtask

  task automatic probe(input int x, input int y, input bit want, input string name);
    xpix = 10'(x);
    ypix = 10'(y);
    #1;
    n_checks++;
    if (pixval !== want) begin
      n_errors++;
      $display("FAIL %s at (%0d,%0d): got %b want %b", name, x, y, pixval, want);
    end
    xpix = '0;
    ypix = '0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (score_l !== 4'd0 || score_r !== 4'd0 || game_over !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got l=%0d r=%0d over=%b want 0 0 0", score_l, score_r, game_over);
    end
    probe(316, 236, 1'b1, "reset_ball_tl");
    probe(315, 236, 1'b0, "reset_ball_left");
    probe(323, 243, 1'b1, "reset_ball_br");
    probe(324, 243, 1'b0, "reset_ball_right");
    probe(20, 208, 1'b1, "reset_lpad_top");
    probe(20, 207, 1'b0, "reset_lpad_above");
    probe(620, 271, 1'b1, "reset_rpad_bottom");
    probe(620, 272, 1'b0, "reset_rpad_below");
    probe(700, 240, 1'b0, "blank_x");
    probe(320, 500, 1'b0, "blank_y");
  endtask

  task automatic test_serve();
    do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    probe(320, 240, 1'b1, "serve_ball_centre");
    for (int i = 0; i < SF; i++) do_tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    probe(316, 236, 1'b1, "serve_end_ball_held");
    do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    probe(317, 240, 1'b0, "play_first_step_left");
    probe(325, 240, 1'b1, "play_first_step_right");
    probe(20, 0, 1'b1, "p1_clamp_top");
    probe(20, 64, 1'b0, "p1_clamp_below");
  endtask

  task automatic test_both_buttons();
    for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    probe(20, 0, 1'b1, "both_p1_top");
    probe(20, 64, 1'b0, "both_p1_below");
    probe(620, 208, 1'b1, "both_p2_top");
    probe(620, 207, 1'b0, "both_p2_above");
  endtask

  task automatic test_game();
    int t;
    t = 0;
    while (m_sl < 1 && t < 2000) begin play_tick(1, 2); t++; end
    if (m_sl < 1) begin
      n_checks++; n_errors++; $display("FAIL right_miss_timeout: got no point in %0d ticks, want one", t);
    end
    t = 0;
    while (m_sr < 1 && t < 2000) begin play_tick(2, 2); t++; end
    if (m_sr < 1) begin
      n_checks++; n_errors++; $display("FAIL left_miss_timeout: got no point in %0d ticks, want one", t);
    end
    n_checks++;
    if (score_r !== 4'd1 || game_over !== 1'b0) begin
      n_errors++; $display("FAIL left_miss: got r=%0d over=%b want 1 0", score_r, game_over);
    end
    probe(316, 236, 1'b1, "miss_ball_recentred");
    t = 0;
    while (m_state != OVER && t < 6000) begin play_tick(1, 2); t++; end
    if (m_state != OVER) begin
      n_checks++; n_errors++; $display("FAIL game_timeout: got no game over in %0d ticks, want one", t);
    end
    n_checks++;
    if (game_over !== 1'b1 || score_l !== 4'(WIN) || score_r !== 4'd1) begin
      n_errors++;
      $display("FAIL win: got over=%b l=%0d r=%0d want 1 %0d 1", game_over, score_l, score_r, WIN);
    end
    do_tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (game_over !== 1'b0 || score_l !== 4'd0 || score_r !== 4'd0) begin
      n_errors++;
      $display("FAIL restart: got over=%b l=%0d r=%0d want 0 0 0", game_over, score_l, score_r);
    end
    for (int i = 0; i < 5; i++) play_tick(1, 1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (score_l !== 4'd0 || score_r !== 4'd0 || game_over !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset: got l=%0d r=%0d over=%b want 0 0 0", score_l, score_r, game_over);
    end
    probe(20, 208, 1'b1, "mid_reset_lpad");
    probe(320, 240, 1'b1, "mid_reset_ball");
    @(negedge clk);
    rst_n = 1'b1;
    do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < SF + 4; i++) play_tick(1, 1);
  endtask

  initial begin
    model_reset();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_serve();
    test_both_buttons();
    test_game();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
